// File: rtl/out_port_arbiter.sv
// Wormhole output-port arbiter: round-robin among head flits in IDLE, then locks
// onto the winning input until its tail flit is forwarded.
module out_port_arbiter #(
    parameter int flit_width = 12,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [flit_width-1:0] flit1,
    input  logic [flit_width-1:0] flit2,
    input  logic [flit_width-1:0] flit3,
    input  logic [flit_width-1:0] flit4,
    input  logic [3:0]            valid,
    input  logic                  out_ready,
    output logic [1:0]            select,
    output logic [3:0]            grant,
    output logic                  out_valid,
    output logic                  err,
    output logic [cnt_width-1:0]  pkt_count
);

    typedef enum logic {IDLE, LOCK} state_e;

    localparam logic [cnt_width-1:0] CntOne = 1;

    state_e               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;

    logic [1:0] flitType [4];
    logic [3:0] eligible;
    logic [1:0] cand;
    logic       candFound;
    logic       xfer;
    logic [1:0] selType;

    assign flitType[0] = flit1[flit_width-1 -: 2];
    assign flitType[1] = flit2[flit_width-1 -: 2];
    assign flitType[2] = flit3[flit_width-1 -: 2];
    assign flitType[3] = flit4[flit_width-1 -: 2];

    // Bit 0 of the type field marks a packet start (head or head+tail).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = valid[i] & flitType[i][0];
        end
    end

    // Scan downward so the offset closest to ptr wins.
    always_comb begin
        cand      = ptr_q;
        candFound = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (eligible[ptr_q + 2'(k)]) begin
                cand      = ptr_q + 2'(k);
                candFound = 1'b1;
            end
        end
    end

    always_comb begin
        select    = 2'd0;
        out_valid = 1'b0;
        if (reset_n) begin
            if (state_q == IDLE) begin
                select    = candFound ? cand : ptr_q;
                out_valid = candFound;
            end else begin
                select    = owner_q;
                out_valid = valid[owner_q];
            end
        end
    end

    assign xfer    = out_valid & out_ready;
    assign grant   = xfer ? (4'b0001 << select) : 4'b0000;
    assign selType = flitType[select];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (state_q == IDLE) begin
                if (selType == 2'b11) begin
                    ptr_d = select + 2'd1;
                    cnt_d = cnt_q + CntOne;
                end else begin
                    state_d = LOCK;
                    owner_d = select;
                end
            end else begin
                // A new head arriving inside a locked packet is a protocol error.
                if (selType[0]) begin
                    err_d = 1'b1;
                end
                if (selType[1]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q + 2'd1;
                    cnt_d   = cnt_q + CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err       = err_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Scoreboard bench for out_port_arbiter: a behavioural model predicts outputs per
// cycle, directed scenarios cover the wormhole cases, then random traffic.
module tb_out_port_arbiter;

    localparam int FW = 12;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [FW-1:0] f [4];
    logic [3:0]    valid;
    logic          out_ready;
    logic [1:0]    select;
    logic [3:0]    grant;
    logic          out_valid;
    logic          err;
    logic [CW-1:0] pkt_count;

    out_port_arbiter #(.flit_width(FW), .cnt_width(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .flit1(f[0]), .flit2(f[1]), .flit3(f[2]), .flit4(f[3]),
        .valid(valid), .out_ready(out_ready),
        .select(select), .grant(grant), .out_valid(out_valid),
        .err(err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    sel;
        logic [3:0]    gnt;
        logic          ov;
        logic          er;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbQ[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model registers (0 = IDLE, 1 = LOCK).
    int         mState = 0;
    logic [1:0] mOwner = 0;
    logic [1:0] mPtr = 0;
    logic       mErr = 0;
    int         mCnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: types holds 2 type bits per input (input i at [2i+1:2i]).
    task automatic applyStimulus(input logic [7:0] types, input logic [3:0] v,
                                 input logic rdy, input logic rstn);
        exp_t       e;
        logic [1:0] t [4];
        logic       found;
        for (int i = 0; i < 4; i++) begin
            t[i] = types[2*i +: 2];
            f[i] = {t[i], 10'($urandom)};
        end
        valid     = v;
        out_ready = rdy;
        reset_n   = rstn;

        e.sel = 2'd0;
        e.ov  = 1'b0;
        e.er  = mErr;
        e.cnt = CW'(mCnt);
        if (rstn) begin
            if (mState == 0) begin
                found = 1'b0;
                e.sel = mPtr;
                for (int k = 0; k < 4; k++) begin
                    logic [1:0] idx;
                    idx = 2'((int'(mPtr) + k) % 4);
                    if (!found && v[idx] && (t[idx] == 2'b01 || t[idx] == 2'b11)) begin
                        found = 1'b1;
                        e.sel = idx;
                    end
                end
                e.ov = found;
            end else begin
                e.sel = mOwner;
                e.ov  = v[mOwner];
            end
        end
        e.gnt = (e.ov && rdy) ? (4'b0001 << e.sel) : 4'b0000;
        sbQ.push_back(e);

        @(negedge clk);
        e = sbQ.pop_front();
        checkOutput("select", 32'(select), 32'(e.sel));
        checkOutput("grant", 32'(grant), 32'(e.gnt));
        checkOutput("outValid", 32'(out_valid), 32'(e.ov));
        checkOutput("err", 32'(err), 32'(e.er));
        checkOutput("pktCount", 32'(pkt_count), 32'(e.cnt));

        @(posedge clk);
        if (!rstn) begin
            mState = 0; mOwner = 0; mPtr = 0; mErr = 0; mCnt = 0;
        end else if (e.ov && rdy) begin
            if (mState == 0) begin
                if (t[e.sel] == 2'b11) begin
                    mCnt = (mCnt + 1) % (1 << CW);
                    mPtr = e.sel + 2'd1;
                end else begin
                    mState = 1;
                    mOwner = e.sel;
                end
            end else begin
                if (t[e.sel] == 2'b01 || t[e.sel] == 2'b11) mErr = 1'b1;
                if (t[e.sel] == 2'b10 || t[e.sel] == 2'b11) begin
                    mState = 0;
                    mCnt = (mCnt + 1) % (1 << CW);
                    mPtr = mOwner + 2'd1;
                end
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) f[i] = '0;
        valid = 4'b0000; out_ready = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;

        applyStimulus(8'h55, 4'b1111, 1'b1, 1'b0);
        applyStimulus(8'h55, 4'b1111, 1'b1, 1'b0);
        checkOutput("resetCnt", 32'(pkt_count), 32'd0);

        // Round-robin over single-flit packets.
        for (int n = 0; n < 5; n++) applyStimulus(8'hFF, 4'b1111, 1'b1, 1'b1);
        checkOutput("cntAfterFive", 32'(pkt_count), 32'd5);

        // Move ptr to 2, then input 2 sends head/body/body/tail against competing heads.
        applyStimulus(8'h0C, 4'b0010, 1'b1, 1'b1);
        applyStimulus(8'h55, 4'b1111, 1'b1, 1'b1);
        applyStimulus(8'h45, 4'b1111, 1'b1, 1'b1);
        applyStimulus(8'h45, 4'b1111, 1'b1, 1'b1);
        applyStimulus(8'h65, 4'b1111, 1'b1, 1'b1);
        applyStimulus(8'h55, 4'b1111, 1'b1, 1'b1);
        checkOutput("grant3Locked", 32'(select), 32'd3);
        applyStimulus(8'h80, 4'b1000, 1'b1, 1'b1);

        // Lock on input 1, stall downstream, let owner go idle, then finish.
        applyStimulus(8'h04, 4'b0010, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) applyStimulus(8'h51, 4'b1111, 1'b0, 1'b1);
        applyStimulus(8'h51, 4'b1111, 1'b1, 1'b1);
        applyStimulus(8'h55, 4'b1101, 1'b1, 1'b1);
        applyStimulus(8'h55, 4'b1101, 1'b1, 1'b1);
        applyStimulus(8'h59, 4'b1111, 1'b1, 1'b1);

        // Body in IDLE is ignored; head inside a locked packet raises sticky err.
        applyStimulus(8'h00, 4'b0001, 1'b1, 1'b1);
        applyStimulus(8'h01, 4'b0001, 1'b1, 1'b1);
        applyStimulus(8'h01, 4'b0001, 1'b1, 1'b1);
        applyStimulus(8'h02, 4'b0001, 1'b1, 1'b1);
        checkOutput("errSticky", 32'(err), 32'd1);
        applyStimulus(8'h03, 4'b0001, 1'b1, 1'b1);
        applyStimulus(8'h00, 4'b0000, 1'b1, 1'b1);

        // Reset abandons a packet locked on input 3.
        applyStimulus(8'h40, 4'b1000, 1'b1, 1'b1);
        applyStimulus(8'h00, 4'b1000, 1'b1, 1'b0);
        checkOutput("errCleared", 32'(err), 32'd0);
        applyStimulus(8'h41, 4'b1001, 1'b1, 1'b1);

        // Counter wrap.
        applyStimulus(8'h00, 4'b0000, 1'b0, 1'b0);
        for (int n = 0; n < 256; n++) applyStimulus(8'hFF, 4'b1111, 1'b1, 1'b1);
        checkOutput("cntWrap", 32'(pkt_count), 32'd0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(8'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 49) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 Parameter: flit_width, default 12, width of every flit bus.
REQ-002 Parameter: cnt_width, default 8, width of the packet counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 flit1, flit2, flit3, flit4  input  flit_width each  head flit of input buffers 0..3.
REQ-006 valid  input  4  valid[i] = input buffer i presents a flit.
REQ-007 out_ready  input  1  downstream accepts a flit this cycle.
REQ-008 select  output  2  drives the 4x1 flit mux select; value i picks flit(i+1).
REQ-009 grant  output  4  one-hot pop strobe to input buffer i; at most one bit set.
REQ-010 out_valid  output  1  muxed flit is valid toward downstream.
REQ-011 err  output  1  sticky protocol-error flag.
REQ-012 pkt_count  output  cnt_width  number of tail flits forwarded, wraps.

Function
REQ-013 Flit type SHALL be bits [flit_width-1:flit_width-2]: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
REQ-014 State SHALL be IDLE or LOCK; registers: state, owner[1:0], ptr[1:0], err, pkt_count.
REQ-015 Transfer SHALL occur in a cycle where out_valid=1 and out_ready=1; grant SHALL equal one-hot(select) in exactly that cycle, else 0.
REQ-016 grant, select and out_valid SHALL be combinational from registers and current inputs (zero latency).
REQ-017 IDLE: eligible input i SHALL have valid[i]=1 and type head or head+tail; candidate SHALL be first eligible in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-018 IDLE with candidate: select=candidate, out_valid=1.
REQ-019 IDLE without candidate: select=ptr, out_valid=0, grant=0.
REQ-020 IDLE transfer of head: next state LOCK, owner=candidate, ptr unchanged.
REQ-021 IDLE transfer of head+tail: stay IDLE, ptr=candidate+1 (mod 4), pkt_count+1.
REQ-022 IDLE: valid non-head flit (body/tail) SHALL NOT be granted and SHALL NOT set err.
REQ-023 LOCK: select=owner, out_valid=valid[owner]; all other inputs ignored regardless of valid.
REQ-024 LOCK transfer of tail or head+tail: next state IDLE, ptr=owner+1 (mod 4), pkt_count+1.
REQ-025 LOCK transfer of body: stay LOCK, no register change.
REQ-026 LOCK transfer of head or head+tail: err set to 1 (sticky); flit still forwarded; head keeps LOCK, head+tail per REQ-024.
REQ-027 out_ready=0: no transfer, no state/ptr/owner/count change, select and out_valid still driven per state.
REQ-028 valid[owner]=0 in LOCK: hold LOCK indefinitely (wormhole), no grant.
REQ-029 pkt_count SHALL wrap from 2^cnt_width-1 to 0.
REQ-030 Fairness: any continuously valid head input SHALL be granted within 4 packet completions.

Reset
REQ-031 While reset_n=0 at a rising edge: state=IDLE, owner=0, ptr=0, err=0, pkt_count=0.
REQ-032 While reset_n=0: grant=0 and out_valid=0 combinationally, select=0.
REQ-033 Reset mid-packet (LOCK) SHALL abandon the packet; next cycle behaves as fresh IDLE with ptr=0.
REQ-034 err SHALL clear only by reset.

Verification
REQ-035 Reset, then valid=1111 all head+tail, out_ready=1 for 5 cycles -> select 0,1,2,3,0; grant 0001,0010,0100,1000,0001; pkt_count=5.
REQ-036 Input 2 sends head,body,body,tail while valid=1111 with others head -> select=2 for 4 consecutive transfers, then ptr=3, next grant 1000.
REQ-037 LOCK owner=1 with out_ready low 3 cycles mid-packet -> grant=0000, select=1, out_valid=1, state unchanged; resumes on out_ready=1.
REQ-038 IDLE, valid=0001 with body flit on flit1 -> out_valid=0, grant=0000, err=0; LOCK owner=0 then head on flit1 -> forwarded, err=1 and stays 1.
REQ-039 pkt_count at 255 (cnt_width=8) plus one tail transfer -> pkt_count=0.
REQ-040 Reset_n low during LOCK owner=3 -> next cycle state IDLE, ptr=0; valid=1001 heads -> select=0, grant=0001.
